// File: rtl/seq_pattern_tx.sv
// Purpose: serial pattern transmitter that shifts a latched pattern MSB first, repeats it, and counts the detector's match pulses.
// Latency: start accepted at edge k puts the first bit on sout in cycle k+1; done pulses in the cycle after the last bit.
// Backpressure: none; start is taken only in IDLE and never queued, and abort cancels a run in progress.
// Optional feature: SEQ_TX_GAP_EN inserts one sout=0 separator cycle between consecutive repetitions.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             match_in,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hits
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef SEQ_TX_GAP_EN
    , GAP = 2'd3
`endif
  } state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] shreg, shreg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [BW-1:0]    bitcnt, bitcnt_d;
  logic [REP_W-1:0] repcnt, repcnt_d;
  logic [HIT_W-1:0] hit_q, hit_d;

  // Register all state; reset parks the block in IDLE with everything cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      pat_q  <= '0;
      bitcnt <= '0;
      repcnt <= '0;
      hit_q  <= '0;
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      pat_q  <= pat_d;
      bitcnt <= bitcnt_d;
      repcnt <= repcnt_d;
      hit_q  <= hit_d;
    end
  end

  // Next-state logic: sequencing of bits and repetitions plus saturating hit counting.
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    pat_d    = pat_q;
    bitcnt_d = bitcnt;
    repcnt_d = repcnt;
    hit_d    = hit_q;

    // Matches count in every non-IDLE state; DONE gives one cycle of slack for a late Mealy match.
    if (state != IDLE && match_in && hit_q != {HIT_W{1'b1}})
      hit_d = hit_q + HIT_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          shreg_d  = pattern;
          pat_d    = pattern;
          repcnt_d = (reps == '0) ? REP_W'(1) : reps;
          bitcnt_d = BIT_LAST;
          hit_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shreg_d = shreg << 1;
          if (bitcnt != '0) begin
            bitcnt_d = bitcnt - BW'(1);
          end else if (repcnt > REP_W'(1)) begin
            repcnt_d = repcnt - REP_W'(1);
            shreg_d  = pat_q;
            bitcnt_d = BIT_LAST;
`ifdef SEQ_TX_GAP_EN
            state_d  = GAP;
`else
            state_d  = SHIFT;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        state_d = abort ? IDLE : SHIFT;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so no input reaches an output combinationally.
  assign sout = (state == SHIFT) & shreg[PAT_W-1];
`ifdef SEQ_TX_GAP_EN
  assign busy = (state == SHIFT) | (state == GAP);
`else
  assign busy = (state == SHIFT);
`endif
  assign done = (state == DONE);
  assign hits = hit_q;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the driving end of the sequence-detector interface. It shifts a latched parallel bit pattern onto a single serial line, one bit per clock, MSB first, for a programmed number of repetitions. It counts the match pulses returned by the downstream detector, so the detector can be exercised in loopback. It sits between a control/test register block and the detector's serial `x` input.

## Interface
- `PAT_W`, default 8: pattern width in bits (≥2).
- `REP_W`, default 4: width of the repetition count.
- `HIT_W`, default 8: width of the match counter.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a transmission; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a transmission in progress.
- `pattern`  in  PAT_W  bits to send; bit PAT_W-1 goes first.
- `reps`  in  REP_W  number of pattern repetitions; 0 is treated as 1.
- `match_in`  in  1  match pulse from the downstream detector.
- `sout`  out  1  serial data; drive to detector `x`.
- `busy`  out  1  high while bits are being sent.
- `done`  out  1  one-cycle pulse after the last bit.
- `hits`  out  HIT_W  count of `match_in` pulses in the current or last run.

## Operation
- Registered state: state, shift register (PAT_W), bit counter, rep counter, hit counter.
- States:
  - IDLE: `sout`=0, `busy`=0.
    - With `start`=1, latch `pattern` into the shift register.
    - Latch `reps` into the rep counter, with 0 forced to 1.
    - Load the bit counter with PAT_W-1, clear `hits`, go to SHIFT.
  - SHIFT: `sout` = shift register MSB, `busy`=1.
    - Each cycle the register shifts left by one.
    - If the bit counter is nonzero, decrement it.
    - If the bit counter is 0 and the rep counter > 1: decrement the rep counter, reload the register from the latched pattern copy, reload the bit counter, and stay in SHIFT (or go to GAP under the macro).
    - If the bit counter is 0 and the rep counter is 1, go to DONE.
  - GAP (macro only): `sout`=0, `busy`=1; one cycle, then SHIFT.
  - DONE: `done`=1, `sout`=0, `busy`=0; next state IDLE.
- `start` outside IDLE is ignored. No queuing.
- `abort`=1 in SHIFT or GAP goes to IDLE on the next edge, with no `done` pulse. `hits` holds its value. `abort` has no effect in IDLE or DONE.
- `start` and `abort` together in IDLE: `start` wins.
- Inputs `pattern` and `reps` are ignored after latching, so they may change mid-run.
- `hits` increments by 1 on each cycle with `match_in`=1 while in SHIFT, GAP or DONE. This covers a Mealy match coincident with the last bit, plus one cycle of slack.
  - `hits` saturates at all-ones (no wrap).
  - `hits` holds in IDLE until the next accepted `start`.

## Timing
- Reset (asynchronous) forces state IDLE and all counters and registers to 0. Outputs after reset: `sout`=0, `busy`=0, `done`=0, `hits`=0.
- Reset mid-run returns to IDLE at once, with no `done` pulse.
- `start` accepted at edge k: first bit (`pattern[PAT_W-1]`) is on `sout` during cycle k+1.
- Without the macro, `busy` is high for exactly PAT_W×R cycles, where R = effective reps. Repetitions are back-to-back with no idle bit.
- `done` is high in the cycle immediately after the last bit. IDLE follows, so a new `start` can be accepted at the edge that ends DONE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- `SEQ_TX_GAP_EN`:
  - Defined: the GAP state is compiled in, inserting one `sout`=0 cycle between consecutive repetitions. Total `busy` cycles = PAT_W×R + (R-1). The detector sees a separator bit.
  - Undefined: the GAP state and its transitions are absent, and repetitions are contiguous.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle during SHIFT -> `sout`=0, `busy`=0, `hits`=0 at once; no `done` pulse.
- Single shot, PAT_W=8, `pattern`=8'b1011_0110, `reps`=1, `start` at edge k:
  - `sout` = 1,0,1,1,0,1,1,0 in cycles k+1..k+8.
  - `done`=1 in cycle k+9, then IDLE.
- Repeat, `pattern`=8'hA5, `reps`=0 then `reps`=3:
  - `reps`=0 -> one copy (8 busy cycles).
  - `reps`=3 -> 24 contiguous bits A5A5A5 (26 cycles with 0 gaps under `SEQ_TX_GAP_EN`).
- Abort/ignore:
  - `start` pulsed during SHIFT -> ignored.
  - `abort` at bit 4 -> IDLE next cycle, `sout`=0, no `done`; a fresh `start` is then accepted.
- Hit counting:
  - Drive `match_in` high on 3 SHIFT cycles plus the DONE cycle -> `hits`=4, held in IDLE, cleared on the next `start`.
  - Force 300 pulses with HIT_W=8 -> `hits`=255.
- Loopback with the serial detector: `sout` drives its `x` and its `z` drives `match_in`. The pattern contains the target sequence twice -> `hits`=2.
